// File: rtl/dump_arbiter.sv
// rtl/dump_arbiter.sv - round-robin owner arbiter for the shared IPbus dump RAM and PC handshake
//
// Purpose: N_CH data channels take turns owning the IPbus DPRAM. The owner's
// write port is registered onto the RAM, and the arbiter runs the
// handshakeFPGA/handshakePC exchange with the PC on the owner's behalf.
//
// Ports:
//   SYSCLK, RESET          clock, asynchronous active-high reset
//   ch_req, ch_done        per-channel level request / burst-complete
//   ch_RAM_data/address/we per-channel RAM write port (packed, channel i at slice i)
//   ch_grant               one-hot ownership grant
//   ch_handshakePC         handshakePC relayed to the owner only
//   IPbus_RAM_*            registered, muxed RAM write port
//   IPbus_ch_id            owner index while handshakeFPGA=1
//   handshakeFPGA          data-ready flag to the PC
//   handshakePC            PC acknowledge
//   dumpCount              completed dumps since reset
//   timeout_err            sticky grant-timeout flag
module dump_arbiter #(
  parameter int N_CH        = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                SYSCLK,
  input  logic                RESET,
  input  logic [N_CH-1:0]     ch_req,
  input  logic [N_CH-1:0]     ch_done,
  input  logic [32*N_CH-1:0]  ch_RAM_data,
  input  logic [8*N_CH-1:0]   ch_RAM_address,
  input  logic [N_CH-1:0]     ch_RAM_we,
  output logic [N_CH-1:0]     ch_grant,
  output logic [N_CH-1:0]     ch_handshakePC,
  output logic [31:0]         IPbus_RAM_data,
  output logic [7:0]          IPbus_RAM_address,
  output logic                IPbus_RAM_we,
  output logic [2:0]          IPbus_ch_id,
  output logic                handshakeFPGA,
  input  logic                handshakePC,
  output logic [31:0]         dumpCount,
  output logic                timeout_err
);

  localparam int OW = $clog2(N_CH);
  localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, GRANT, HANDSHAKE, WAITREL} state_t;

  state_t         state, state_n;
  logic [OW-1:0]  owner, owner_n;
  logic [OW-1:0]  last_owner, last_owner_n;
  logic [15:0]    tcnt, tcnt_n;
  logic [31:0]    dump_cnt, dump_cnt_n;
  logic           terr, terr_n;
  logic [31:0]    ram_data;
  logic [7:0]     ram_addr;
  logic           ram_we;
  logic           hpc_q;

  // Owner's slice of every per-channel input
  logic           own_req, own_done, own_we;
  logic [31:0]    own_data;
  logic [7:0]     own_addr;

  always_comb begin
    own_req  = 1'b0;
    own_done = 1'b0;
    own_we   = 1'b0;
    own_data = '0;
    own_addr = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (owner == OW'(i)) begin
        own_req  = ch_req[i];
        own_done = ch_done[i];
        own_we   = ch_RAM_we[i];
        own_data = ch_RAM_data[32*i +: 32];
        own_addr = ch_RAM_address[8*i +: 8];
      end
    end
  end

  // Round-robin pick: requesters above last_owner win first (lowest of them),
  // otherwise wrap around to the lowest requester at or below last_owner.
  logic           hi_found, lo_found;
  logic [OW-1:0]  hi_pick, lo_pick;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_pick  = '0;
    lo_pick  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_req[i]) begin
        if (OW'(i) > last_owner) begin
          hi_found = 1'b1;
          hi_pick  = OW'(i);
        end else begin
          lo_found = 1'b1;
          lo_pick  = OW'(i);
        end
      end
    end
  end

  // State register and datapath registers
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(N_CH - 1);
      tcnt       <= '0;
      dump_cnt   <= '0;
      terr       <= 1'b0;
      ram_data   <= '0;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      hpc_q      <= 1'b0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_owner_n;
      tcnt       <= tcnt_n;
      dump_cnt   <= dump_cnt_n;
      terr       <= terr_n;
      hpc_q      <= handshakePC;
      ram_we     <= (state == GRANT) && own_we;
      if (state == GRANT) begin
        ram_data <= own_data;
        ram_addr <= own_addr;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_owner_n = last_owner;
    tcnt_n       = tcnt;
    dump_cnt_n   = dump_cnt;
    terr_n       = terr;
    case (state)
      IDLE: begin
        if (hi_found || lo_found) begin
          owner_n = hi_found ? hi_pick : lo_pick;
          tcnt_n  = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        tcnt_n = tcnt + 16'd1;
        if (own_done) begin
          state_n = HANDSHAKE;
        end else if (!own_req) begin
          last_owner_n = owner;
          state_n      = IDLE;
        end else if (tcnt == TCNT_LAST) begin
          terr_n       = 1'b1;
          last_owner_n = owner;
          state_n      = IDLE;
        end
      end
      HANDSHAKE: begin
        if (handshakePC) state_n = WAITREL;
      end
      WAITREL: begin
        if (!handshakePC && !own_done) begin
          dump_cnt_n   = dump_cnt + 32'd1;
          last_owner_n = owner;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output decode, from registered state only
  always_comb begin
    ch_grant       = '0;
    ch_handshakePC = '0;
    handshakeFPGA  = (state == HANDSHAKE);
    IPbus_ch_id    = (state == HANDSHAKE) ? 3'(owner) : 3'd0;
    for (int i = 0; i < N_CH; i++) begin
      if (owner == OW'(i) && state != IDLE) begin
        ch_grant[i]       = 1'b1;
        ch_handshakePC[i] = hpc_q && (state == HANDSHAKE || state == WAITREL);
      end
    end
  end

  assign IPbus_RAM_data    = ram_data;
  assign IPbus_RAM_address = ram_addr;
  assign IPbus_RAM_we      = ram_we;
  assign dumpCount         = dump_cnt;
  assign timeout_err       = terr;

endmodule

// File: tb/tb_dump_arbiter.sv
// tb/tb_dump_arbiter.sv - scoreboard bench for dump_arbiter
module tb_dump_arbiter;
  localparam int N = 4;

  logic            SYSCLK = 1'b0;
  logic            RESET  = 1'b1;
  logic [N-1:0]    ch_req = '0, ch_done = '0, ch_RAM_we = '0;
  logic [32*N-1:0] ch_RAM_data = '0;
  logic [8*N-1:0]  ch_RAM_address = '0;
  logic [N-1:0]    ch_grant, ch_handshakePC;
  logic [31:0]     IPbus_RAM_data, dumpCount;
  logic [7:0]      IPbus_RAM_address;
  logic            IPbus_RAM_we, handshakeFPGA, timeout_err;
  logic [2:0]      IPbus_ch_id;
  logic            handshakePC = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_dumps = 0;
  logic [39:0] wr_q[$];
  int          grant_q[$];

  dump_arbiter #(.N_CH(N), .TIMEOUT_CYC(16)) dut (
    .SYSCLK(SYSCLK), .RESET(RESET),
    .ch_req(ch_req), .ch_done(ch_done),
    .ch_RAM_data(ch_RAM_data), .ch_RAM_address(ch_RAM_address), .ch_RAM_we(ch_RAM_we),
    .ch_grant(ch_grant), .ch_handshakePC(ch_handshakePC),
    .IPbus_RAM_data(IPbus_RAM_data), .IPbus_RAM_address(IPbus_RAM_address),
    .IPbus_RAM_we(IPbus_RAM_we), .IPbus_ch_id(IPbus_ch_id),
    .handshakeFPGA(handshakeFPGA), .handshakePC(handshakePC),
    .dumpCount(dumpCount), .timeout_err(timeout_err)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  // IPbus write monitor, sampled mid-cycle
  always @(negedge SYSCLK) begin
    if (!RESET && IPbus_RAM_we) begin
      if (wr_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        logic [39:0] e;
        e = wr_q.pop_front();
        check("ram_addr", {24'd0, IPbus_RAM_address}, {24'd0, e[39:32]});
        check("ram_data", IPbus_RAM_data, e[31:0]);
      end
    end
  end

  // Owner writes nw words (addr w, data base+w); every other channel toggles junk writes
  task automatic write_words(input int own, input int nw, input logic [31:0] base);
    for (int w = 0; w < nw; w++) begin
      for (int c = 0; c < N; c++) begin
        ch_RAM_data[32*c +: 32]  = (c == own) ? base + 32'(w) : $urandom;
        ch_RAM_address[8*c +: 8] = (c == own) ? 8'(w) : 8'($urandom);
        ch_RAM_we[c]             = (c == own) ? 1'b1 : 1'($urandom);
      end
      wr_q.push_back({8'(w), base + 32'(w)});
      tick();
    end
    ch_RAM_we = '0;
    tick();
  endtask

  task automatic do_dump(input int nw);
    int own;
    int n;
    own = grant_q.pop_front();
    n = 0;
    while (ch_grant == '0 && n < 20) begin
      tick();
      n++;
    end
    check("grant_owner", {28'd0, ch_grant}, 32'(1 << own));
    write_words(own, nw, 32'hC000_0000 | 32'(own << 8));
    ch_done[own] = 1'b1;
    tick();
    check("hs_fpga_set", {31'd0, handshakeFPGA}, 32'd1);
    check("ch_id", {29'd0, IPbus_ch_id}, 32'(own));
    handshakePC = 1'b1;
    tick();
    check("hs_pc_relay", {28'd0, ch_handshakePC}, 32'(1 << own));
    check("hs_fpga_clr", {31'd0, handshakeFPGA}, 32'd0);
    handshakePC = 1'b0;
    ch_done[own] = 1'b0;
    tick();
    exp_dumps++;
    check("grant_released", {28'd0, ch_grant}, 32'd0);
    check("dump_count", dumpCount, 32'(exp_dumps));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #23;
    check("rst_grant", {28'd0, ch_grant}, 32'd0);
    check("rst_hs_fpga", {31'd0, handshakeFPGA}, 32'd0);
    check("rst_dumps", dumpCount, 32'd0);
    check("rst_terr", {31'd0, timeout_err}, 32'd0);
    check("rst_we", {31'd0, IPbus_RAM_we}, 32'd0);
    RESET = 1'b0;
    tick();

    // Single request: grant one cycle later, writes 0xA0..0xA3
    ch_req = 4'b0001;
    tick();
    check("grant_latency", {28'd0, ch_grant}, 32'd1);
    write_words(0, 4, 32'hA0);
    ch_done[0] = 1'b1;
    tick();
    check("single_hs_fpga", {31'd0, handshakeFPGA}, 32'd1);
    check("single_id", {29'd0, IPbus_ch_id}, 32'd0);
    handshakePC = 1'b1;
    tick();
    check("single_pc_relay", {28'd0, ch_handshakePC}, 32'd1);
    handshakePC = 1'b0;
    ch_done[0] = 1'b0;
    ch_req = '0;
    tick();
    check("single_dumps", dumpCount, 32'd1);
    check("single_release", {28'd0, ch_grant}, 32'd0);

    // Round-robin from a fresh reset
    RESET = 1'b1;
    #3;
    RESET = 1'b0;
    exp_dumps = 0;
    ch_req = 4'b1111;
    foreach (grant_q[i]) grant_q.delete(i);
    grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(2);
    grant_q.push_back(3); grant_q.push_back(0);
    for (int k = 0; k < 5; k++) do_dump(2);
    ch_req = '0;
    tick();

    // Abort by owner 2 while channel 3 waits
    ch_req = 4'b0100;
    tick();
    check("abort_grant2", {28'd0, ch_grant}, 32'h4);
    ch_req[3] = 1'b1;
    write_words(2, 2, 32'hB0);
    ch_req[2] = 1'b0;
    tick();
    check("abort_idle", {28'd0, ch_grant}, 32'd0);
    check("abort_dumps", dumpCount, 32'(exp_dumps));
    tick();
    check("abort_next3", {28'd0, ch_grant}, 32'h8);

    // Channel 3 never finishes: timeout after 16 granted cycles
    n = 1;
    tick();
    while (ch_grant != '0 && n < 40) begin
      n++;
      tick();
    end
    ch_req = '0;
    check("timeout_cycles", 32'(n), 32'd16);
    check("timeout_err", {31'd0, timeout_err}, 32'd1);
    check("timeout_dumps", dumpCount, 32'(exp_dumps));

    // A later dump leaves timeout_err sticky
    tick();
    ch_req = 4'b0010;
    grant_q.push_back(1);
    do_dump(3);
    ch_req = '0;
    check("terr_sticky", {31'd0, timeout_err}, 32'd1);

    // Done and request drop in the same GRANT cycle: done wins
    ch_req = 4'b0100;
    tick();
    check("sim_grant", {28'd0, ch_grant}, 32'h4);
    ch_done[2] = 1'b1;
    ch_req[2] = 1'b0;
    tick();
    check("sim_hs_fpga", {31'd0, handshakeFPGA}, 32'd1);
    check("sim_grant_held", {28'd0, ch_grant}, 32'h4);
    handshakePC = 1'b1;
    tick();
    handshakePC = 1'b0;
    ch_done[2] = 1'b0;
    tick();
    exp_dumps++;
    check("sim_dumps", dumpCount, 32'(exp_dumps));

    // Asynchronous reset during HANDSHAKE
    ch_req = 4'b0001;
    tick();
    check("rst_test_grant", {28'd0, ch_grant}, 32'h1);
    ch_done[0] = 1'b1;
    tick();
    check("rst_test_hs", {31'd0, handshakeFPGA}, 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    check("async_hs_fpga", {31'd0, handshakeFPGA}, 32'd0);
    check("async_grant", {28'd0, ch_grant}, 32'd0);
    check("async_dumps", dumpCount, 32'd0);
    ch_done = '0;
    ch_req = 4'b1000;
    #1;
    RESET = 1'b0;
    tick();
    check("post_rst_grant3", {28'd0, ch_grant}, 32'h8);
    ch_req = '0;
    tick();
    tick();
    check("wr_queue_empty", 32'(wr_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
